// File: rtl/toothless_pkg.sv
// ============================================================================
// Module      : toothless_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package toothless_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

  // Canonical NOP (addi x0, x0, 0) used as the payload of faulted entries
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage : toothless_pkg

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Single-outstanding instruction fetch stage. Issues one
//               req/gnt/rvalid transaction per instruction, holds the result
//               in an output register for the decoder and pulses pc_en_o
//               when the decoder consumes an entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import toothless_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  input  logic                   flush_i,
  output logic                   instr_req_o,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  input  logic                   instr_gnt_i,
  input  logic                   instr_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] instr_rdata_i,
  input  logic                   instr_err_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic                   fetch_err_o,
  output logic                   misaligned_o,
  output logic                   pc_en_o
);

  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(INSTR_NOP);

  fetch_state_e           state;
  fetch_state_e           next_state;

  logic [ADDR_WIDTH-1:0]  pc_q;
  logic                   discard_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  instr_pc_q;
  logic                   fetch_err_q;
  logic                   misaligned_q;

  logic                   misaligned_pc;
  logic                   drop_resp;

  // A word-misaligned PC never reaches the bus; it becomes a fault entry
  assign misaligned_pc = (pc_i[1:0] != 2'b00);
  // A response is dropped if a flush arrived earlier or arrives with it
  assign drop_resp     = discard_q | flush_i;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = REQ;
      REQ: begin
        if (misaligned_pc) begin
          next_state = VALID;
        end else if (instr_gnt_i) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (instr_rvalid_i) begin
          next_state = drop_resp ? REQ : VALID;
        end
      end
      VALID: begin
        if (flush_i || instr_ready_i) begin
          next_state = REQ;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: bus request, handshake valid and PC-advance pulse
  always_comb begin
    instr_req_o   = 1'b0;
    instr_addr_o  = pc_i;
    instr_valid_o = 1'b0;
    pc_en_o       = 1'b0;
    case (state)
      REQ:   instr_req_o = ~misaligned_pc;
      VALID: begin
        instr_valid_o = 1'b1;
        pc_en_o       = instr_ready_i & ~flush_i;
      end
      default: ;
    endcase
  end

  // Captured PC, discard tracking and the held output entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= '0;
      discard_q    <= 1'b0;
      instr_q      <= NOP_WORD;
      instr_pc_q   <= '0;
      fetch_err_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (misaligned_pc) begin
            instr_q      <= NOP_WORD;
            instr_pc_q   <= pc_i;
            misaligned_q <= 1'b1;
            fetch_err_q  <= 1'b0;
          end else if (instr_gnt_i) begin
            pc_q <= pc_i;
          end
        end
        RESP: begin
          if (instr_rvalid_i) begin
            discard_q <= 1'b0;
            if (!drop_resp) begin
              instr_q      <= instr_err_i ? NOP_WORD : instr_rdata_i;
              instr_pc_q   <= pc_q;
              fetch_err_q  <= instr_err_i;
              misaligned_q <= 1'b0;
            end
          end else if (flush_i) begin
            discard_q <= 1'b1;
          end
        end
        VALID: begin
          if (flush_i || instr_ready_i) begin
            fetch_err_q  <= 1'b0;
            misaligned_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_o      = instr_q;
  assign instr_pc_o   = instr_pc_q;
  assign fetch_err_o  = fetch_err_q;
  assign misaligned_o = misaligned_q;

endmodule : instr_fetch

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch. The bench plays
//               the memory side by hand; outputs are sampled 1 time unit
//               after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        fetch_err_o;
  logic        misaligned_o;
  logic        pc_en_o;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(.INSTR_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_i          (pc_i),
    .flush_i       (flush_i),
    .instr_req_o   (instr_req_o),
    .instr_addr_o  (instr_addr_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i (instr_rdata_i),
    .instr_err_i   (instr_err_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .fetch_err_o   (fetch_err_o),
    .misaligned_o  (misaligned_o),
    .pc_en_o       (pc_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with idle bus, release, and step into REQ
  task automatic do_reset(input logic [31:0] pc);
    rst_n = 1'b0; pc_i = pc; flush_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0; instr_ready_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_i = 32'h0001_0074; flush_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0; instr_ready_i = 1'b0;
    tick(); tick();
    n_checks++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%0b exp=0", instr_req_o); end
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", instr_valid_o); end
    n_checks++; if (pc_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_pc_en got=%0b exp=0", pc_en_o); end
    n_checks++; if (fetch_err_o !== 1'b0 || misaligned_o !== 1'b0) begin n_fail++; $display("FAIL rst_faults got=%0b%0b exp=00", fetch_err_o, misaligned_o); end
    n_checks++; if (instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_instr got=%h exp=00000013", instr_o); end
    n_checks++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_instr_pc got=%h exp=00000000", instr_pc_o); end
    rst_n = 1'b1;
    tick();
    // zero-wait memory: grant in the request cycle, response the next
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0001_0074) begin n_fail++; $display("FAIL zw_req got=%0b/%h exp=1/00010074", instr_req_o, instr_addr_o); end
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    n_checks++; if (instr_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL zw_resp got req=%0b valid=%0b exp=0/0", instr_req_o, instr_valid_o); end
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0050_0093;
    tick();
    instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    n_checks++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL zw_valid got=%0b exp=1", instr_valid_o); end
    n_checks++; if (instr_o !== 32'h0050_0093) begin n_fail++; $display("FAIL zw_instr got=%h exp=00500093", instr_o); end
    n_checks++; if (instr_pc_o !== 32'h0001_0074) begin n_fail++; $display("FAIL zw_instr_pc got=%h exp=00010074", instr_pc_o); end
    n_checks++; if (pc_en_o !== 1'b0) begin n_fail++; $display("FAIL zw_pc_en_idle got=%0b exp=0", pc_en_o); end
    instr_ready_i = 1'b1;
    #1;
    n_checks++; if (pc_en_o !== 1'b1) begin n_fail++; $display("FAIL zw_pc_en got=%0b exp=1", pc_en_o); end
    tick();
    instr_ready_i = 1'b0;
    n_checks++; if (pc_en_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL zw_after got pc_en=%0b valid=%0b exp=0/0", pc_en_o, instr_valid_o); end
    n_checks++; if (instr_req_o !== 1'b1) begin n_fail++; $display("FAIL zw_next_req got=%0b exp=1", instr_req_o); end
  endtask

  task automatic test_wait_states();
    do_reset(32'h0000_0200);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0000_0200) begin n_fail++; $display("FAIL ws_req_hold[%0d] got=%0b/%h exp=1/00000200", i, instr_req_o, instr_addr_o); end
      tick();
    end
    instr_gnt_i = 1'b1;
    n_checks++; if (instr_req_o !== 1'b1) begin n_fail++; $display("FAIL ws_req_at_gnt got=%0b exp=1", instr_req_o); end
    tick();
    instr_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (instr_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL ws_resp_wait[%0d] got req=%0b valid=%0b exp=0/0", i, instr_req_o, instr_valid_o); end
      tick();
    end
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF;
    tick();
    instr_rvalid_i = 1'b0;
    n_checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'hDEAD_BEEF || instr_pc_o !== 32'h0000_0200) begin n_fail++; $display("FAIL ws_out got=%0b/%h/%h exp=1/deadbeef/00000200", instr_valid_o, instr_o, instr_pc_o); end
  endtask

  task automatic test_backpressure();
    do_reset(32'h0000_0300);
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'h00A0_0113;
    tick();
    instr_rvalid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h00A0_0113) begin n_fail++; $display("FAIL bp_hold[%0d] got=%0b/%h exp=1/00a00113", i, instr_valid_o, instr_o); end
      n_checks++; if (instr_req_o !== 1'b0 || pc_en_o !== 1'b0) begin n_fail++; $display("FAIL bp_quiet[%0d] got req=%0b pc_en=%0b exp=0/0", i, instr_req_o, pc_en_o); end
      // a stray response outside RESP must not disturb the held entry
      instr_rvalid_i = (i == 2); instr_rdata_i = 32'h1111_1111;
      tick();
      instr_rvalid_i = 1'b0;
    end
    n_checks++; if (instr_o !== 32'h00A0_0113) begin n_fail++; $display("FAIL bp_stray got=%h exp=00a00113", instr_o); end
    instr_ready_i = 1'b1;
    #1;
    n_checks++; if (pc_en_o !== 1'b1) begin n_fail++; $display("FAIL bp_pc_en got=%0b exp=1", pc_en_o); end
    tick();
    instr_ready_i = 1'b0;
    n_checks++; if (instr_req_o !== 1'b1 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_next got req=%0b valid=%0b exp=1/0", instr_req_o, instr_valid_o); end
  endtask

  task automatic test_bus_error();
    do_reset(32'h0000_0400);
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1; instr_err_i = 1'b1; instr_rdata_i = 32'h1234_5678;
    tick();
    instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
    n_checks++; if (fetch_err_o !== 1'b1 || misaligned_o !== 1'b0) begin n_fail++; $display("FAIL be_flags got err=%0b mis=%0b exp=1/0", fetch_err_o, misaligned_o); end
    n_checks++; if (instr_o !== 32'h0000_0013 || instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL be_out got=%h/%0b exp=00000013/1", instr_o, instr_valid_o); end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    n_checks++; if (fetch_err_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL be_clear got err=%0b valid=%0b exp=0/0", fetch_err_o, instr_valid_o); end
  endtask

  task automatic test_misaligned();
    do_reset(32'h0001_0076);
    n_checks++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL mis_no_req got=%0b exp=0", instr_req_o); end
    tick();
    n_checks++; if (misaligned_o !== 1'b1 || instr_valid_o !== 1'b1 || fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL mis_flags got mis=%0b valid=%0b err=%0b exp=1/1/0", misaligned_o, instr_valid_o, fetch_err_o); end
    n_checks++; if (instr_pc_o !== 32'h0001_0076 || instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL mis_out got=%h/%h exp=00010076/00000013", instr_pc_o, instr_o); end
    n_checks++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL mis_no_req2 got=%0b exp=0", instr_req_o); end
    instr_ready_i = 1'b1;
    #1;
    n_checks++; if (pc_en_o !== 1'b1) begin n_fail++; $display("FAIL mis_pc_en got=%0b exp=1", pc_en_o); end
    tick();
    instr_ready_i = 1'b0; pc_i = 32'h0000_0500;
    #1;
    n_checks++; if (misaligned_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== 32'h0000_0500) begin n_fail++; $display("FAIL mis_recover got mis=%0b req=%0b addr=%h exp=0/1/00000500", misaligned_o, instr_req_o, instr_addr_o); end
  endtask

  task automatic test_flush_resp();
    do_reset(32'h0000_0600);
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; pc_i = 32'h0000_0700;
    tick();
    n_checks++; if (instr_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL fr_wait got req=%0b valid=%0b exp=0/0", instr_req_o, instr_valid_o); end
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0BAD_0BAD;
    tick();
    instr_rvalid_i = 1'b0;
    n_checks++; if (instr_valid_o !== 1'b0 || pc_en_o !== 1'b0) begin n_fail++; $display("FAIL fr_dropped got valid=%0b pc_en=%0b exp=0/0", instr_valid_o, pc_en_o); end
    n_checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0000_0700) begin n_fail++; $display("FAIL fr_new_req got=%0b/%h exp=1/00000700", instr_req_o, instr_addr_o); end
    n_checks++; if (instr_o === 32'h0BAD_0BAD) begin n_fail++; $display("FAIL fr_instr got=%h exp=not 0bad0bad", instr_o); end
    // discard must be cleared: next transaction delivers normally
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0030_0193;
    tick();
    instr_rvalid_i = 1'b0;
    n_checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0030_0193 || instr_pc_o !== 32'h0000_0700) begin n_fail++; $display("FAIL fr_after got=%0b/%h/%h exp=1/00300193/00000700", instr_valid_o, instr_o, instr_pc_o); end
  endtask

  task automatic test_flush_valid();
    do_reset(32'h0000_0800);
    instr_gnt_i = 1'b1;
    tick();
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0040_0213;
    tick();
    instr_rvalid_i = 1'b0;
    instr_ready_i = 1'b1; flush_i = 1'b1;
    #1;
    n_checks++; if (pc_en_o !== 1'b0) begin n_fail++; $display("FAIL fv_pc_en got=%0b exp=0", pc_en_o); end
    tick();
    instr_ready_i = 1'b0; flush_i = 1'b0;
    n_checks++; if (instr_valid_o !== 1'b0 || instr_req_o !== 1'b1) begin n_fail++; $display("FAIL fv_after got valid=%0b req=%0b exp=0/1", instr_valid_o, instr_req_o); end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_backpressure();
    test_bus_error();
    test_misaligned();
    test_flush_resp();
    test_flush_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_instr_fetch

`default_nettype wire
